// File: rtl/serpent_pkg.sv
// Shared constants, state encoding and word rotate for the streaming Serpent key schedule.
package serpent_pkg;

  localparam logic [31:0] PHI           = 32'h9e3779b9;
  localparam int          NUM_SUBKEYS_C = 33;
  localparam int          PREKEY_WORDS  = 132;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [31:0] rol11(input logic [31:0] x);
    return {x[20:0], x[31:21]};
  endfunction

endpackage

// File: rtl/serpent_key_schedule_stream_sboxes.sv
// Combinational bitsliced Serpent S-box: bit b of words 0..3 forms one nibble, selected box by sbox_idx.
module serpent_key_schedule_stream_sboxes (
  input  logic [31:0]  w0,
  input  logic [31:0]  w1,
  input  logic [31:0]  w2,
  input  logic [31:0]  w3,
  input  logic [2:0]   sbox_idx,
  output logic [127:0] result
);

  logic [63:0] table_sel;
  logic [3:0]  nib_out;

  // Each table packs entry n at bits [4n+3:4n].
  always_comb begin
    table_sel = 64'h0;
    case (sbox_idx)
      3'd0: table_sel = 64'hc90724deb56a1f83;
      3'd1: table_sel = 64'h43d68eb1a50972cf;
      3'd2: table_sel = 64'h25b04e1dfac39768;
      3'd3: table_sel = 64'he57a421d369c8bf0;
      3'd4: table_sel = 64'hd7e9a4526b0c38f1;
      3'd5: table_sel = 64'h176d8e30c9a4b25f;
      3'd6: table_sel = 64'h0a3df19eb6485c27;
      default: table_sel = 64'h6539ac47b28e0fd1;
    endcase
  end

  always_comb begin
    result  = '0;
    nib_out = '0;
    for (int b = 0; b < 32; b++) begin
      nib_out = table_sel[{w3[b], w2[b], w1[b], w0[b], 2'b00} +: 4];
      result[b]      = nib_out[0];
      result[32 + b] = nib_out[1];
      result[64 + b] = nib_out[2];
      result[96 + b] = nib_out[3];
    end
  end

endmodule

// File: rtl/serpent_key_schedule_stream.sv
// Streaming Serpent key schedule: rolling 8-word prekey window, LANES words per cycle, valid/ready subkey port.
// Define SERPENT_KS_IP_EN to emit subkeys through the initial permutation (standard, non-bitsliced form).
//
// state | meaning
// IDLE  | waiting for i_begin; o_busy low
// GEN   | generating prekey words and emitting K0..K(N-1)
// DRAIN | last subkey registered, waiting for its handshake
module serpent_key_schedule_stream
  import serpent_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int NUM_SUBKEYS = NUM_SUBKEYS_C
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_begin,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_key_len,
  output logic         o_busy,
  output logic [127:0] o_subkey,
  output logic [5:0]   o_address,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_done
);

  localparam int TOTAL_WORDS = 4 * NUM_SUBKEYS;

  state_t              state, state_n;
  logic [31:0]         window [8];
  logic [31:0]         ext [8 + LANES];
  logic [32*LANES-1:0] new_words;
  logic [127:0]        stage, stage_n, subkey_q, sbox_out;
  logic [255:0]        padded;
  logic [2:0]          fill, fill_n;
  logic [7:0]          word_idx;
  logic [5:0]          k;
  logic                accept, stage_full, out_free, move, gen, last_move, final_hs;

  always_comb begin
    padded = i_key;
    case (i_key_len)
      KEY_LEN_128: padded = {127'b0, 1'b1, i_key[127:0]};
      KEY_LEN_192: padded = {63'b0, 1'b1, i_key[191:0]};
      default:     padded = i_key;
    endcase
  end

  // Later lanes chain on words produced earlier in the same cycle.
  always_comb begin
    new_words = '0;
    for (int j = 0; j < 8; j++) ext[j] = window[j];
    for (int j = 0; j < LANES; j++) begin
      ext[8 + j] = rol11(ext[j] ^ ext[j + 3] ^ ext[j + 5] ^ ext[j + 7] ^ PHI
                         ^ (32'(word_idx) + 32'(j)));
      new_words[32*j +: 32] = ext[8 + j];
    end
  end

  // Staging is a shift register; after 4/LANES shifts word0 sits at the bottom.
  generate
    if (LANES == 4) begin : g_stage_full_width
      assign stage_n = new_words;
    end else begin : g_stage_shift
      assign stage_n = {new_words, stage[127:32*LANES]};
    end
  endgenerate

  always_comb begin
    stage_full = (fill == 3'd4);
    out_free   = !o_valid || i_ready;
    move       = (state == GEN) && stage_full && out_free;
    gen        = (state == GEN) && (word_idx < 8'(TOTAL_WORDS)) && (!stage_full || move);
    accept     = (state == IDLE) && i_begin && !o_busy && !o_done;
    last_move  = move && (k == 6'(NUM_SUBKEYS - 1));
    final_hs   = (state == DRAIN) && o_valid && i_ready;
    fill_n     = (move ? 3'd0 : fill) + (gen ? 3'(LANES) : 3'd0);
    state_n    = state;
    case (state)
      IDLE:    if (accept) state_n = GEN;
      GEN:     if (last_move) state_n = DRAIN;
      DRAIN:   if (final_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  serpent_key_schedule_stream_sboxes u_sboxes (
    .w0       (stage[31:0]),
    .w1       (stage[63:32]),
    .w2       (stage[95:64]),
    .w3       (stage[127:96]),
    .sbox_idx (3'(3'd3 - k[2:0])),
    .result   (sbox_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < 8; j++) window[j] <= '0;
      stage     <= '0;
      fill      <= '0;
      word_idx  <= '0;
      k         <= '0;
      subkey_q  <= '0;
      o_address <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= final_hs;
      if (accept) begin
        for (int j = 0; j < 8; j++) window[j] <= padded[32*j +: 32];
        stage    <= '0;
        fill     <= '0;
        word_idx <= '0;
        k        <= '0;
        o_busy   <= 1'b1;
      end else begin
        fill <= fill_n;
        if (gen) begin
          for (int j = 0; j < 8; j++) window[j] <= ext[LANES + j];
          stage    <= stage_n;
          word_idx <= word_idx + 8'(LANES);
        end
        if (move) begin
          subkey_q  <= sbox_out;
          o_address <= k;
          k         <= k + 6'd1;
          o_valid   <= 1'b1;
        end else if (o_valid && i_ready) begin
          o_valid <= 1'b0;
        end
        if (final_hs) o_busy <= 1'b0;
      end
    end
  end

`ifdef SERPENT_KS_IP_EN
  function automatic logic [127:0] ip_perm(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = x[(i % 4) * 32 + i / 4];
    return r;
  endfunction

  assign o_subkey = ip_perm(subkey_q);
`else
  assign o_subkey = subkey_q;
`endif

endmodule

// File: tb/tb_serpent_key_schedule_stream.sv
// Bench for serpent_key_schedule_stream: LANES=4 and LANES=1 instances against an array-based key expansion model.
module tb_serpent_key_schedule_stream;

  localparam int NK = 33;

  logic         clk = 1'b0;
  logic         rst [2];
  logic         start [2];
  logic [255:0] key [2];
  logic [1:0]   key_len [2];
  logic         ready [2];
  logic         busy [2];
  logic [127:0] subkey [2];
  logic [5:0]   address [2];
  logic         valid [2];
  logic         done [2];

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_sk [NK];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serpent_key_schedule_stream #(.LANES(g == 0 ? 4 : 1)) dut (
      .i_clk     (clk),
      .i_rst     (rst[g]),
      .i_begin   (start[g]),
      .i_key     (key[g]),
      .i_key_len (key_len[g]),
      .o_busy    (busy[g]),
      .o_subkey  (subkey[g]),
      .o_address (address[g]),
      .o_valid   (valid[g]),
      .i_ready   (ready[g]),
      .o_done    (done[g])
    );
  end

  int sb [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  // Full 140-word prekey array, then the 33 bitsliced subkeys.
  function automatic void model(input logic [255:0] kk, input logic [1:0] ln);
    logic [255:0] p;
    logic [31:0]  w [140];
    logic [31:0]  t;
    logic [127:0] r, q;
    logic [3:0]   v;
    int           s, nib;
    p = kk;
    if (ln == 2'b00) begin
      for (int b = 128; b < 256; b++) p[b] = 1'b0;
      p[128] = 1'b1;
    end else if (ln == 2'b01) begin
      for (int b = 192; b < 256; b++) p[b] = 1'b0;
      p[192] = 1'b1;
    end
    for (int j = 0; j < 8; j++) w[j] = p[32*j +: 32];
    for (int i = 0; i < 132; i++) begin
      t = w[i] ^ w[i + 3] ^ w[i + 5] ^ w[i + 7] ^ 32'h9e3779b9 ^ 32'(i);
      w[i + 8] = (t << 11) | (t >> 21);
    end
    for (int kx = 0; kx < NK; kx++) begin
      s = (35 - kx) % 8;
      r = '0;
      for (int b = 0; b < 32; b++) begin
        nib = 8 * int'(w[4*kx + 11][b]) + 4 * int'(w[4*kx + 10][b])
            + 2 * int'(w[4*kx + 9][b]) + int'(w[4*kx + 8][b]);
        v = 4'(sb[s][nib]);
        r[b] = v[0]; r[32 + b] = v[1]; r[64 + b] = v[2]; r[96 + b] = v[3];
      end
`ifdef SERPENT_KS_IP_EN
      for (int i = 0; i < 128; i++) q[i] = r[(i % 4) * 32 + i / 4];
      r = q;
`else
      q = r;
`endif
      exp_sk[kx] = q;
    end
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic draw(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // mode: 0 plain, 1 i_begin while busy, 2 reset after K10, 3 i_begin on o_done
  task automatic run(input int vi, input int u, input logic [255:0] kk, input logic [1:0] ln,
                     input int pct, input int mode, input logic [127:0] k0_exp);
    int n, hs, last_hs;
    logic pv, pr, fin, stop;
    logic [127:0] psk;
    logic [5:0] pa;
    model(kk, ln);
    @(posedge clk); #1;
    key[u] = kk; key_len[u] = ln; start[u] = 1'b1; ready[u] = draw(pct);
    @(posedge clk); #1;
    start[u] = 1'b0; key[u] = rand_key(); key_len[u] = 2'($urandom);
    n = 0; hs = 0; last_hs = 0; pv = 0; pr = 0; fin = 0; stop = 0; psk = '0; pa = '0;
    while (!stop) begin
      @(negedge clk);
      n++;
      if (fin) begin
        check($sformatf("v%0d_done_pulse", vi), 128'(done[u]), 128'd1);
        check($sformatf("v%0d_valid_after_done", vi), 128'(valid[u]), 128'd0);
        check($sformatf("v%0d_busy_after_done", vi), 128'(busy[u]), 128'd0);
        stop = 1;
        if (mode == 3) begin
          start[u] = 1'b1; key[u] = rand_key();
          @(posedge clk); #1;
          start[u] = 1'b0;
          @(negedge clk);
          check($sformatf("v%0d_begin_on_done_ignored", vi), 128'(busy[u]), 128'd0);
        end
      end else begin
        if (pv && !pr) begin
          check($sformatf("v%0d_hold_valid", vi), 128'(valid[u]), 128'd1);
          check($sformatf("v%0d_hold_subkey", vi), subkey[u], psk);
          check($sformatf("v%0d_hold_address", vi), 128'(address[u]), 128'(pa));
        end
        if (valid[u] && ready[u]) begin
          check($sformatf("v%0d_k%0d_address", vi, hs), 128'(address[u]), 128'(hs));
          check($sformatf("v%0d_k%0d_subkey", vi, hs), subkey[u], hs == 0 ? k0_exp : exp_sk[hs]);
          if (pct == 100) begin
            if (hs == 0 && u == 0) check($sformatf("v%0d_k0_latency", vi), 128'(n), 128'd3);
            if (hs > 0) check($sformatf("v%0d_k%0d_interval", vi, hs), 128'(n - last_hs),
                              128'(u == 0 ? 1 : 4));
          end
          last_hs = n;
          hs++;
          if (hs == NK) fin = 1;
          if (mode == 2 && hs == 11) begin
            @(posedge clk); #1;
            rst[u] = 1'b1;
            @(posedge clk); #1;
            rst[u] = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_reset_valid", vi), 128'(valid[u]), 128'd0);
            check($sformatf("v%0d_reset_busy", vi), 128'(busy[u]), 128'd0);
            for (int c = 0; c < 4; c++) begin
              @(negedge clk);
              check($sformatf("v%0d_reset_quiet", vi), 128'(valid[u]), 128'd0);
            end
            stop = 1;
          end
        end
        if (n > 3000) begin
          checks++; errors++;
          $display("FAIL v%0d_timeout: got %0d handshakes expected %0d", vi, hs, NK);
          stop = 1;
        end
      end
      if (!stop) begin
        pv = valid[u]; pr = ready[u]; psk = subkey[u]; pa = address[u];
        @(posedge clk); #1;
        ready[u] = draw(pct);
        if (mode == 1 && (n == 4 || n == 9)) begin
          start[u] = 1'b1; key[u] = ~kk; key_len[u] = 2'b10;
        end else begin
          start[u] = 1'b0;
        end
      end
    end
    ready[u] = 1'b0;
    start[u] = 1'b0;
  endtask

  typedef struct {
    int           u;
    logic [255:0] key;
    logic [1:0]   len;
    int           pct;
    int           mode;
    logic [127:0] k0;
  } vec_t;

  vec_t vecs [11];
  logic [255:0] shared_key;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; start[u] = 1'b0; key[u] = '0; key_len[u] = '0; ready[u] = 1'b0;
    end
    shared_key = rand_key();
    vecs[0]  = '{0, 256'h0, 2'b10, 100, 0, '0};
    vecs[1]  = '{0, 256'h80, 2'b00, 100, 0, '0};
    vecs[2]  = '{0, rand_key(), 2'b01, 100, 0, '0};
    vecs[3]  = '{0, {4{64'h0123456789abcdef}}, 2'b11, 100, 0, '0};
    vecs[4]  = '{1, shared_key, 2'b00, 100, 0, '0};
    vecs[5]  = '{1, shared_key, 2'b00, 30, 0, '0};
    vecs[6]  = '{0, rand_key(), 2'b10, 30, 1, '0};
    vecs[7]  = '{1, rand_key(), 2'b10, 100, 2, '0};
    vecs[8]  = '{1, rand_key(), 2'b01, 100, 0, '0};
    vecs[9]  = '{0, rand_key(), 2'b01, 100, 3, '0};
    vecs[10] = '{0, rand_key(), 2'b00, 50, 0, '0};
    for (int i = 0; i < 11; i++) begin
      model(vecs[i].key, vecs[i].len);
      vecs[i].k0 = exp_sk[0];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_valid_%0d", u), 128'(valid[u]), 128'd0);
      check($sformatf("reset_busy_%0d", u), 128'(busy[u]), 128'd0);
      check($sformatf("reset_done_%0d", u), 128'(done[u]), 128'd0);
      check($sformatf("reset_subkey_%0d", u), subkey[u], 128'd0);
      check($sformatf("reset_address_%0d", u), 128'(address[u]), 128'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int i = 0; i < 11; i++)
      run(i, vecs[i].u, vecs[i].key, vecs[i].len, vecs[i].pct, vecs[i].mode, vecs[i].k0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serpent_key_schedule_stream.md
Name: serpent_key_schedule_stream

Overview:
- Parametrised successor to the slow Serpent key schedule.
- Expands a 128/192/256-bit user key into the 33 Serpent round subkeys K0..K32.
- Keeps only an 8-word rolling prekey window, not a 140-word array.
- Produces LANES prekey words per cycle and streams subkeys over a valid/ready port to the XTS round-key store, so the consumer can apply backpressure.

Parameters:
- LANES, 4, prekey words generated per cycle. Legal values: 1, 2, 4. LANES=4 gives one subkey per cycle.
- NUM_SUBKEYS, 33, number of subkeys emitted. Fixed by Serpent; exposed for bench shortening only.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_begin  in  1  start request; accepted only when o_busy=0.
- i_key  in  256  user key. i_key[31:0] is w(-8) … i_key[255:224] is w(-1).
- i_key_len  in  2  00=128, 01=192, 10=256; 11 treated as 256.
- o_busy  out  1  high from the cycle after acceptance until o_done.
- o_subkey  out  128  subkey {word3,word2,word1,word0} after S-box.
- o_address  out  6  subkey index 0..32 of o_subkey.
- o_valid  out  1  o_subkey/o_address valid.
- i_ready  in  1  consumer accepts when o_valid&i_ready.
- o_done  out  1  one-cycle pulse after the handshake of K32.

Behaviour:
- Reset (i_rst high at a clock edge): all outputs and internal registers go to 0; state IDLE. Reset mid-operation aborts immediately with no further o_valid.
- Key padding at acceptance:
  - Key bits at positions ≥ len are replaced with 0.
  - Bit position len is set to 1 for 128 and 192.
  - No padding for 256.
- Generation rule: w(i) = ROL11(w(i-8) ^ w(i-5) ^ w(i-3) ^ w(i-1) ^ 32'h9e3779b9 ^ i), for i = 0..131.
  - The window shifts by LANES words per generation step.
  - Chained words within one cycle use the same-cycle results.
- S-box selection: subkey k uses words w(4k..4k+3) with S-box index (3-k) mod 8; the S-box is combinational.
- States:
  - IDLE: i_begin=1 → load padded window, word counter i=0, subkey counter k=0, go to GEN. o_busy=1 next cycle.
  - GEN: a 4-word staging buffer fills at LANES words per cycle.
    - When staging holds 4 words and the output register is empty or being drained (o_valid&i_ready), the S-box result is registered: o_valid=1, o_address=k, k++, staging cleared.
    - Generation stalls while staging is full and output is blocked.
    - When k reaches NUM_SUBKEYS → DRAIN.
  - DRAIN: wait for the final handshake. Then o_valid=0, o_done pulses for 1 cycle, o_busy=0, go to IDLE.
- Output rules:
  - o_subkey and o_address are held stable while o_valid & !i_ready.
  - o_valid never drops without a handshake, except on reset.
- Latency with i_ready tied high:
  - LANES=4: K0 is valid 3 cycles after the i_begin edge, then one subkey per cycle. o_done pulses the cycle after the K32 handshake.
  - LANES=2 or LANES=1: the subkey rate is 1 per 2 or 1 per 4 cycles respectively.
- i_begin while o_busy=1 is ignored; there is no restart.
- i_begin in the same cycle as o_done: ignored; accepted from the next cycle.
- i_key and i_key_len are sampled only at acceptance.

Optional Feature:
- SERPENT_KS_IP_EN defined: the registered o_subkey is passed through the Serpent initial permutation IP, giving standard (non-bitsliced) subkeys. Latency is unchanged because IP is pure wiring.
- SERPENT_KS_IP_EN undefined: bitsliced subkeys, bit-identical to the existing key schedule's output.

Decomposition:
- serpent_pkg holds:
  - PHI = 32'h9e3779b9;
  - NUM_SUBKEYS_C = 33;
  - PREKEY_WORDS = 132;
  - the key_len encoding localparams;
  - the state enum (IDLE/GEN/DRAIN);
  - the ROL11 function.
- One sub-module: reuse the existing sboxes unit (words 0..3 plus S-box index) as the single combinational S-box instance. The IP permutation is an inline function, not a module.

Test Plan:
- 256-bit key of all zeros, LANES=4, i_ready=1 → 33 handshakes, addresses 0..32, K0 matches the NESSIE zero-key vector, o_done 1 cycle after K32, o_busy low after.
- 128-bit key 0x000…0080 (bit 7 set), i_key_len=00 → window padded with bit 128 set; all 33 subkeys match the reference model's 128-bit expansion.
- i_ready toggled randomly at 30% duty, LANES=1 → o_subkey/o_address stable whenever o_valid&!i_ready; identical subkey sequence to the i_ready=1 run.
- i_begin pulsed while o_busy=1 with a different key → ignored; output sequence still belongs to the first key.
- i_rst asserted after the K10 handshake → o_valid=0, o_busy=0 next edge. A new i_begin then produces a full 0..32 sequence.
- Build with SERPENT_KS_IP_EN defined → K0 equals IP applied to the non-IP build's K0, for key 256'h0123…cdef.
